dcache_wt: RTL and testbench

- Direct-mapped, write-through data cache between the pipeline MEM stage and a slower main-memory port with a request/acknowledge handshake.
- Replaces the single-cycle data memory in front of MEMWB.
- On a read miss or any write, it raises cpu_stall. The pipeline freezes and holds address and control stable until cpu_stall drops.
- Each line holds one 32-bit word. Two 16-bit saturating performance counters (hits, misses) are included.

---
 rtl/dcache_wt.sv | 129 ++++++++++++
 tb/tb_dcache_wt.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wt.sv
// Direct-mapped write-through data cache, one 32-bit word per line.
// Ports: cpu_* from MEM stage, mem_* req/ack memory port, hit/miss counters.
module dcache_wt #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_MISS,
    S_WR_THRU
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];
  logic             r_done;
  logic             r_replay;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_idle;
  logic             w_wr_go;
  logic             w_rd_hit;
  logic             w_rd_miss;
  logic             w_fill;
  logic             w_unused;

  assign w_idx    = cpu_addr[IDX_W+1:2];
  assign w_tag    = cpu_addr[31:IDX_W+2];
  assign w_unused = ^cpu_addr[1:0];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_idle   = (r_state == S_IDLE);

  // r_done masks the still-held store right after its ack
  assign w_wr_go   = cpu_wr & ~r_done;
  assign w_rd_hit  = cpu_rd & ~cpu_wr & w_hit;
  assign w_rd_miss = cpu_rd & ~cpu_wr & ~w_hit;

  // state is forced to IDLE by reset, so an aborted miss never fills
  assign w_fill = ~w_idle & mem_ack;

  assign cpu_stall = ~w_idle | w_wr_go | w_rd_miss;
  assign cpu_rdata = (w_idle && cpu_rd && w_hit) ? r_data[w_idx] : 32'h0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_go)        w_next = S_WR_THRU;
        else if (w_rd_miss) w_next = S_RD_MISS;
      end
      S_RD_MISS: if (mem_ack) w_next = S_IDLE;
      S_WR_THRU: if (mem_ack) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_done    <= 1'b0;
      r_replay  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      r_state  <= w_next;
      r_done   <= (r_state == S_WR_THRU) & mem_ack;
      r_replay <= (r_state == S_RD_MISS) & mem_ack;
      if (w_idle && w_wr_go) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= {cpu_addr[31:2], 2'b00};
        mem_wdata <= cpu_wdata;
      end else if (w_idle && w_rd_miss) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= {cpu_addr[31:2], 2'b00};
      end else if (w_fill) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (w_fill) r_valid[w_idx] <= 1'b1;
      // the replayed access after a fill is not a new hit
      if (w_idle && w_rd_hit && !r_replay && hit_cnt != '1)
        hit_cnt <= hit_cnt + ONE;
      if (w_idle && w_rd_miss && miss_cnt != '1)
        miss_cnt <= miss_cnt + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= (r_state == S_WR_THRU) ? cpu_wdata : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: stimulus pushes expected load data
// and memory requests; negedge monitor pops and compares.
module tb_dcache_wt;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  dcache_wt #(.IDX_W(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rdq[$];
  logic [64:0] memq[$];
  logic prev_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got output want none", nm);
  endtask

  always @(negedge clock) begin : monitor
    logic [31:0] e;
    logic [64:0] m;
    if (reset) begin
      if (cpu_rd && !cpu_stall) begin
        if (rdq.size() == 0) unexp("rdata_unexpected");
        else begin
          e = rdq.pop_front();
          chk("rdata", cpu_rdata, e);
        end
      end
      if (mem_req && !prev_req) begin
        if (memq.size() == 0) unexp("mem_req_unexpected");
        else begin
          m = memq.pop_front();
          chk("mem_we", {31'h0, mem_we}, {31'h0, m[64]});
          chk("mem_addr", mem_addr, m[63:32]);
          if (m[64]) chk("mem_wdata", mem_wdata, m[31:0]);
        end
      end
    end
    prev_req = mem_req;
  end

  // exp: load data (memory supplies it on a miss) or store data
  task automatic access(input bit wr, input logic [31:0] addr,
                        input logic [31:0] exp, input bit miss,
                        input int k, output int sn);
    int rc;
    bit done;
    sn = 0;
    rc = 0;
    done = 0;
    @(posedge clock); #1;
    cpu_addr  = addr;
    cpu_wdata = wr ? exp : 32'h0;
    cpu_wr    = wr;
    cpu_rd    = !wr;
    if (wr) memq.push_back({1'b1, addr, exp});
    else begin
      rdq.push_back(exp);
      if (miss) memq.push_back({1'b0, addr, 32'h0});
    end
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (!cpu_stall) done = 1;
      else begin
        sn++;
        if (mem_req) begin
          if (rc == k) begin
            mem_ack   = 1'b1;
            mem_rdata = exp;
            chk("hold_addr", mem_addr, addr);
          end
          rc++;
        end
      end
    end
    if (!done) unexp("stall_timeout");
    @(posedge clock); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  initial begin : stim
    int sn;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
    chk("rst_hit", {16'h0, hit_cnt}, 32'h0);
    chk("rst_miss", {16'h0, miss_cnt}, 32'h0);

    access(0, 32'h40, 32'hDEADBEEF, 1, 3, sn);
    chk("miss_stall", sn, 5);
    chk("miss_cnt1", {16'h0, miss_cnt}, 32'd1);
    chk("hit_cnt0", {16'h0, hit_cnt}, 32'd0);

    access(0, 32'h40, 32'hDEADBEEF, 0, 0, sn);
    chk("hit_stall", sn, 0);
    chk("hit_cnt1", {16'h0, hit_cnt}, 32'd1);

    access(1, 32'h80, 32'h12345678, 0, 0, sn);
    access(0, 32'h80, 32'h12345678, 0, 0, sn);
    chk("st_ld_stall", sn, 0);
    chk("hit_cnt2", {16'h0, hit_cnt}, 32'd2);

    // 0x40, 0x80, 0x440 all map to index 0
    access(0, 32'h40, 32'hDEADBEEF, 1, 0, sn);
    chk("evict_stall", sn, 2);
    access(0, 32'h440, 32'hCAFEF00D, 1, 1, sn);
    chk("conf_stall", sn, 3);
    chk("miss_cnt3", {16'h0, miss_cnt}, 32'd3);
    access(0, 32'h40, 32'hDEADBEEF, 1, 2, sn);
    chk("reload_stall", sn, 4);
    chk("miss_cnt4", {16'h0, miss_cnt}, 32'd4);
    chk("hit_cnt2b", {16'h0, hit_cnt}, 32'd2);

    // abort a miss with reset while the request is outstanding
    @(posedge clock); #1;
    cpu_addr = 32'h440;
    cpu_rd   = 1'b1;
    memq.push_back({1'b0, 32'h440, 32'h0});
    repeat (3) @(negedge clock);
    chk("abort_pre_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b0;
    #1;
    chk("abort_req", {31'h0, mem_req}, 32'h0);
    chk("abort_hit", {16'h0, hit_cnt}, 32'h0);
    chk("abort_miss", {16'h0, miss_cnt}, 32'h0);
    cpu_rd = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;

    access(0, 32'h40, 32'h0BADF00D, 1, 0, sn);
    chk("post_rst_stall", sn, 2);
    chk("post_rst_miss", {16'h0, miss_cnt}, 32'd1);
    chk("post_rst_hit", {16'h0, hit_cnt}, 32'd0);

    // saturate the hit counter with back-to-back hits
    @(posedge clock); #1;
    cpu_addr = 32'h40;
    cpu_rd   = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      rdq.push_back(32'h0BADF00D);
      @(posedge clock); #1;
    end
    cpu_rd = 1'b0;
    chk("sat_max", {16'h0, hit_cnt}, 32'h0000FFFF);
    cpu_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rdq.push_back(32'h0BADF00D);
      @(posedge clock); #1;
    end
    cpu_rd = 1'b0;
    chk("sat_hold", {16'h0, hit_cnt}, 32'h0000FFFF);
    chk("sat_miss", {16'h0, miss_cnt}, 32'd1);

    repeat (3) @(posedge clock);
    chk("rdq_empty", rdq.size(), 0);
    chk("memq_empty", memq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
